// File: rtl/id_stage_if.sv
// Fetch/hazard/writeback <-> decode bundle for id_stage.
// master drives the decode inputs; slave is the decode stage itself.
interface id_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [DW-1:0] InstrD, PCPlus4D, ALUOutM, ResultW;
  logic          ForwardAD, ForwardBD, RegWriteW, FlushE;
  logic [AW-1:0] WriteRegW;

  logic          PCSrcD, BranchD;
  logic [DW-1:0] PCBranchD;
  logic [AW-1:0] RsD, RtD;

  logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]    ALUControlE;
  logic [AW-1:0] RsE, RtE, RdE;
  logic [DW-1:0] RD1E, RD2E, SignImmE;

  modport master (
    output InstrD, PCPlus4D, ALUOutM, ResultW, ForwardAD, ForwardBD,
           RegWriteW, FlushE, WriteRegW,
    input  PCSrcD, BranchD, PCBranchD, RsD, RtD,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RsE, RtE, RdE, RD1E, RD2E, SignImmE
  );

  modport slave (
    input  InstrD, PCPlus4D, ALUOutM, ResultW, ForwardAD, ForwardBD,
           RegWriteW, FlushE, WriteRegW,
    output PCSrcD, BranchD, PCBranchD, RsD, RtD,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RsE, RtE, RdE, RD1E, RD2E, SignImmE
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file with W->D write-through, main/ALU decode,
// early beq resolution and the ID/EX pipeline register.
module id_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave bus
);
  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0]    w_op, w_funct;
  logic [AW-1:0] w_rs, w_rt, w_rd;
  logic [DW-1:0] w_simm, w_rd1, w_rd2, w_a, w_b;
  logic          w_regwrite, w_memtoreg, w_memwrite, w_alusrc, w_regdst, w_branch;
  logic [2:0]    w_aluctl;

  logic [DW-1:0] r_rf [NREG];

  logic          r_regwrite, r_memtoreg, r_memwrite, r_alusrc, r_regdst;
  logic [2:0]    r_aluctl;
  logic [AW-1:0] r_rs, r_rt, r_rd;
  logic [DW-1:0] r_rd1, r_rd2, r_simm;

  assign w_op    = bus.InstrD[31:26];
  assign w_rs    = bus.InstrD[25:21];
  assign w_rt    = bus.InstrD[20:16];
  assign w_rd    = bus.InstrD[15:11];
  assign w_funct = bus.InstrD[5:0];
  assign w_simm  = {{(DW-16){bus.InstrD[15]}}, bus.InstrD[15:0]};

  // Reads see the value being written back this cycle; r0 always reads 0.
  always_comb begin
    w_rd1 = r_rf[w_rs];
    if (w_rs == '0)
      w_rd1 = '0;
    else if (bus.RegWriteW && bus.WriteRegW == w_rs)
      w_rd1 = bus.ResultW;
  end

  always_comb begin
    w_rd2 = r_rf[w_rt];
    if (w_rt == '0)
      w_rd2 = '0;
    else if (bus.RegWriteW && bus.WriteRegW == w_rt)
      w_rd2 = bus.ResultW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (bus.RegWriteW && bus.WriteRegW != '0) begin
      r_rf[bus.WriteRegW] <= bus.ResultW;
    end
  end

  always_comb begin
    w_regwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_regdst   = 1'b0;
    w_branch   = 1'b0;
    w_aluctl   = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        case (w_funct)
          6'h20:   w_aluctl = ALU_ADD;
          6'h22:   w_aluctl = ALU_SUB;
          6'h24:   w_aluctl = ALU_AND;
          6'h25:   w_aluctl = ALU_OR;
          6'h2A:   w_aluctl = ALU_SLT;
          // includes the all-zero fetch bubble: must never write back
          default: w_regwrite = 1'b0;
        endcase
      end
      OP_LW: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_memtoreg = 1'b1;
      end
      OP_SW: begin
        w_memwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      OP_BEQ: begin
        w_branch = 1'b1;
        w_aluctl = ALU_SUB;
      end
      OP_ADDI: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_a = bus.ForwardAD ? bus.ALUOutM : w_rd1;
  assign w_b = bus.ForwardBD ? bus.ALUOutM : w_rd2;

  assign bus.PCSrcD    = w_branch & (w_a == w_b);
  assign bus.PCBranchD = bus.PCPlus4D + w_simm;
  assign bus.BranchD   = w_branch;
  assign bus.RsD       = w_rs;
  assign bus.RtD       = w_rt;

  // Reset and flush both leave a clean bubble in execute.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_aluctl   <= ALU_ADD;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_simm     <= '0;
    end else begin
      r_regwrite <= w_regwrite;
      r_memtoreg <= w_memtoreg;
      r_memwrite <= w_memwrite;
      r_alusrc   <= w_alusrc;
      r_regdst   <= w_regdst;
      r_aluctl   <= w_aluctl;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_rd       <= w_rd;
      r_rd1      <= w_rd1;
      r_rd2      <= w_rd2;
      r_simm     <= w_simm;
    end
  end

  assign bus.RegWriteE   = r_regwrite;
  assign bus.MemtoRegE   = r_memtoreg;
  assign bus.MemWriteE   = r_memwrite;
  assign bus.ALUSrcE     = r_alusrc;
  assign bus.RegDstE     = r_regdst;
  assign bus.ALUControlE = r_aluctl;
  assign bus.RsE         = r_rs;
  assign bus.RtE         = r_rt;
  assign bus.RdE         = r_rd;
  assign bus.RD1E        = r_rd1;
  assign bus.RD2E        = r_rd2;
  assign bus.SignImmE    = r_simm;
endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage: decode-side outputs checked before the
// edge, the ID/EX bundle checked just after it.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_if #(.DW(32), .AW(5)) bus ();
  id_stage #(.NREG(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] instr, pcp4, aluoutm, res;
    logic        fa, fb, rw, flush;
    logic [4:0]  wreg;
    logic        e_pcsrc, e_br;
    logic [31:0] e_pcbr;
    logic [4:0]  e_ctl;   // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst}
    logic [2:0]  e_alu;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_rd1, e_rd2, e_imm;
  } vec_t;

  vec_t vecs[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic vec_t v(
    input logic [31:0] instr, input logic [31:0] pcp4,
    input logic fa, input logic fb, input logic [31:0] aluoutm,
    input logic rw, input logic [4:0] wreg, input logic [31:0] res,
    input logic flush,
    input logic pcsrc, input logic [31:0] pcbr, input logic br,
    input logic [4:0] ctl, input logic [2:0] alu,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
    vec_t t;
    t.instr = instr; t.pcp4 = pcp4; t.fa = fa; t.fb = fb; t.aluoutm = aluoutm;
    t.rw = rw; t.wreg = wreg; t.res = res; t.flush = flush;
    t.e_pcsrc = pcsrc; t.e_pcbr = pcbr; t.e_br = br;
    t.e_ctl = ctl; t.e_alu = alu; t.e_rs = rs; t.e_rt = rt; t.e_rd = rd;
    t.e_rd1 = rd1; t.e_rd2 = rd2; t.e_imm = imm;
    return t;
  endfunction

  function automatic logic [118:0] pk(
    input logic [4:0] ctl, input logic [2:0] alu, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rd1,
    input logic [31:0] rd2, input logic [31:0] imm);
    return {ctl, alu, rs, rt, rd, rd1, rd2, imm};
  endfunction

  function automatic logic [118:0] ex_act();
    return {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE,
            bus.ALUControlE, bus.RsE, bus.RtE, bus.RdE, bus.RD1E, bus.RD2E, bus.SignImmE};
  endfunction

  task automatic chk(input string name, input logic [118:0] act, input logic [118:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.InstrD = t.instr; bus.PCPlus4D = t.pcp4;
    bus.ForwardAD = t.fa; bus.ForwardBD = t.fb; bus.ALUOutM = t.aluoutm;
    bus.RegWriteW = t.rw; bus.WriteRegW = t.wreg; bus.ResultW = t.res;
    bus.FlushE = t.flush;
  endtask

  initial begin
    vec_t t;
    logic [118:0] exp_d, act_d;

    // r8 write attempted during reset must be dropped
    rst_n = 1'b0;
    drive(v(32'h8C080004, 0, 0, 0, 0, 1, 5'd8, 32'h55, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex", ex_act(), pk(5'b00000, 3'b010, 0, 0, 0, 0, 0, 0));

    //        instr         pcp4   fa fb aluM  rw wr  res      fl pcsrc pcbr   br ctl       alu     rs rt rd  rd1     rd2     imm
    vecs.push_back(v(32'h8C080004, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h4,    0, 5'b11010, 3'b010, 0, 8, 0,  0,      0,      32'h4));
    vecs.push_back(v(32'h00000000, 32'h0,  0, 0, 0,    1, 9,  32'h1234,0, 0, 32'h0,    0, 5'b00001, 3'b010, 0, 0, 0,  0,      0,      32'h0));
    vecs.push_back(v(32'h01295020, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h5020, 0, 5'b10001, 3'b010, 9, 9, 10, 32'h1234,32'h1234,32'h5020));
    vecs.push_back(v(32'h01295020, 32'h0,  0, 0, 0,    1, 9,  32'hAA,  0, 0, 32'h5020, 0, 5'b10001, 3'b010, 9, 9, 10, 32'hAA,  32'hAA,  32'h5020));
    vecs.push_back(v(32'h00004020, 32'h0,  0, 0, 0,    1, 0,  32'hFF,  0, 0, 32'h4020, 0, 5'b10001, 3'b010, 0, 0, 8,  0,      0,      32'h4020));
    vecs.push_back(v(32'h00004020, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h4020, 0, 5'b10001, 3'b010, 0, 0, 8,  0,      0,      32'h4020));
    vecs.push_back(v(32'h00000000, 32'h0,  0, 0, 0,    1, 1,  32'h5,   0, 0, 32'h0,    0, 5'b00001, 3'b010, 0, 0, 0,  0,      0,      32'h0));
    vecs.push_back(v(32'h00000000, 32'h0,  0, 0, 0,    1, 2,  32'h7,   0, 0, 32'h0,    0, 5'b00001, 3'b010, 0, 0, 0,  0,      0,      32'h0));
    vecs.push_back(v(32'h10220003, 32'h10, 0, 1, 32'h5,0, 0,  0,       0, 1, 32'h13,   1, 5'b00000, 3'b110, 1, 2, 0,  32'h5,  32'h7,  32'h3));
    vecs.push_back(v(32'h10220003, 32'h10, 0, 0, 32'h5,0, 0,  0,       0, 0, 32'h13,   1, 5'b00000, 3'b110, 1, 2, 0,  32'h5,  32'h7,  32'h3));
    vecs.push_back(v(32'h10220003, 32'h10, 1, 0, 32'h7,0, 0,  0,       0, 1, 32'h13,   1, 5'b00000, 3'b110, 1, 2, 0,  32'h5,  32'h7,  32'h3));
    vecs.push_back(v(32'h8C080004, 32'h10, 0, 0, 0,    0, 0,  0,       1, 0, 32'h14,   0, 5'b00000, 3'b010, 0, 0, 0,  0,      0,      32'h0));
    vecs.push_back(v(32'hAC0A0008, 32'h10, 0, 0, 0,    0, 0,  0,       0, 0, 32'h18,   0, 5'b00110, 3'b010, 0, 10,0,  0,      0,      32'h8));
    vecs.push_back(v(32'h2001FFFC, 32'h10, 0, 0, 0,    0, 0,  0,       0, 0, 32'hC,    0, 5'b10010, 3'b010, 0, 1, 31, 0,      32'h5,  32'hFFFFFFFC));
    vecs.push_back(v(32'hFC221234, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h1234, 0, 5'b00000, 3'b010, 1, 2, 2,  32'h5,  32'h7,  32'h1234));
    vecs.push_back(v(32'h00221822, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h1822, 0, 5'b10001, 3'b110, 1, 2, 3,  32'h5,  32'h7,  32'h1822));
    vecs.push_back(v(32'h00221824, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h1824, 0, 5'b10001, 3'b000, 1, 2, 3,  32'h5,  32'h7,  32'h1824));
    vecs.push_back(v(32'h00221825, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h1825, 0, 5'b10001, 3'b001, 1, 2, 3,  32'h5,  32'h7,  32'h1825));
    vecs.push_back(v(32'h0022182A, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h182A, 0, 5'b10001, 3'b111, 1, 2, 3,  32'h5,  32'h7,  32'h182A));
    vecs.push_back(v(32'h00221826, 32'h0,  0, 0, 0,    0, 0,  0,       0, 0, 32'h1826, 0, 5'b00001, 3'b010, 1, 2, 3,  32'h5,  32'h7,  32'h1826));

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t);
      #3;
      exp_d = {t.e_pcsrc, t.e_pcbr, t.e_br, t.instr[25:21], t.instr[20:16]};
      act_d = {bus.PCSrcD, bus.PCBranchD, bus.BranchD, bus.RsD, bus.RtD};
      chk($sformatf("vec%0d_dec", i), act_d, exp_d);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ex", i), ex_act(),
          pk(t.e_ctl, t.e_alu, t.e_rs, t.e_rt, t.e_rd, t.e_rd1, t.e_rd2, t.e_imm));
    end

    // Mid-run reset: clears the file, drops the concurrent r1 write.
    rst_n = 1'b0;
    drive(v(32'h00221822, 0, 0, 0, 0, 1, 5'd1, 32'h99, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("midreset_ex", ex_act(), pk(5'b00000, 3'b010, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    bus.RegWriteW = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_read", ex_act(), pk(5'b10001, 3'b110, 1, 2, 3, 0, 0, 32'h1822));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage pipeline, directly downstream of instruction fetch.
- Consumes InstrD and PCPlus4D from the fetch stage.
- Returns PCSrcD and PCBranchD to fetch. Branches resolve early, in decode.
- Holds the 32x32 register file and main/ALU decoders, and registers the decoded bundle into the ID/EX pipeline register for execute.

Parameters:
- NREG, 32, number of architectural registers. Index width is 5; register 0 is hardwired to zero.
- DW, 32, datapath width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset: synchronous and active-low.
- InstrD  input  32  instruction word from fetch.
- PCPlus4D  input  32  next sequential PC from fetch (word-addressed, PC+1).
- ForwardAD  input  1  select ALUOutM instead of RD1 for the branch compare.
- ForwardBD  input  1  select ALUOutM instead of RD2 for the branch compare.
- ALUOutM  input  32  memory-stage ALU result used for branch forwarding.
- RegWriteW  input  1  write-back enable.
- WriteRegW  input  5  write-back register index.
- ResultW  input  32  write-back data.
- FlushE  input  1  insert bubble into ID/EX (hazard unit: load-use stall or branch).
- PCSrcD  output  1  taken-branch select to fetch (combinational).
- PCBranchD  output  32  branch target to fetch (combinational).
- BranchD  output  1  current decode instruction is beq (for hazard unit).
- RsD, RtD  output  5 each  source indices of the current decode instruction (for hazard unit).
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1 each  registered controls.
- ALUControlE  output  3  registered ALU op.
- RsE, RtE, RdE  output  5 each  registered register indices.
- RD1E, RD2E, SignImmE  output  32 each  registered operands and sign-extended immediate.

Behaviour:
- Field decode:
  - op = InstrD[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - SignImmD = sign-extend InstrD[15:0] to 32 bits.
- Supported opcodes:
  - R-type 0x00: RegWrite=1, RegDst=1.
  - lw 0x23: RegWrite=1, ALUSrc=1, MemtoReg=1, ALU add.
  - sw 0x2B: MemWrite=1, ALUSrc=1, ALU add.
  - beq 0x04: Branch=1, ALU sub.
  - addi 0x08: RegWrite=1, ALUSrc=1, ALU add.
  - Any other opcode decodes as NOP: all controls 0, ALUControl 010.
- R-type funct to ALUControl:
  - add 0x20 -> 010, sub 0x22 -> 110, and 0x24 -> 000, or 0x25 -> 001, slt 0x2A -> 111.
  - Unknown funct -> 010 with RegWrite forced to 0.
- Register file:
  - Two combinational read ports (rs, rt); one write port on the rising clk edge when RegWriteW=1 and WriteRegW != 0.
  - Writes to register 0 are ignored; reads of register 0 return 0.
  - Write-through: if a read index equals WriteRegW and RegWriteW=1 in the same cycle (index != 0), the read returns ResultW. This gives same-cycle W->D bypass.
- Branch:
  - A = ForwardAD ? ALUOutM : RD1; B = ForwardBD ? ALUOutM : RD2.
  - PCSrcD = BranchD & (A == B).
  - PCBranchD = PCPlus4D + SignImmD, modulo 2^32. Word addressing, so no shift by 2; wrap-around is ignored.
  - InstrD = 0 (the bubble fetch inserts on a taken branch) decodes as R-type sll-shaped funct 0. This is treated as unknown funct: no write, no branch.
- ID/EX register, one-cycle latency:
  - On each rising edge the decoded bundle loads into the *E outputs.
  - If FlushE=1, all control outputs (RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE) load 0 and ALUControlE loads 010. Data/index outputs load 0.
  - There is no hold/enable: the register updates every cycle.
- Reset (rst_n=0 at a rising edge):
  - All *E outputs become 0 except ALUControlE = 010.
  - All registers in the file clear to 0.
  - Takes priority over FlushE and over the write port.
  - Mid-operation reset discards any pending write-back in that cycle.
  - PCSrcD, PCBranchD, BranchD, RsD and RtD remain combinational functions of inputs and current state.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with InstrD=0x8C080004 -> all *E outputs 0, ALUControlE=010; a following read of r8 returns 0.
- Write then read:
  - Stimulus: RegWriteW=1, WriteRegW=9, ResultW=0x1234 for one cycle, then InstrD=0x01295020 (add r10,r9,r9).
  - Required: next edge gives RD1E=RD2E=0x1234, RdE=10, RegDstE=1, ALUControlE=010.
- Write-through and r0:
  - Same-cycle write of r9=0xAA while decoding rs=9 -> RD1E=0xAA.
  - A write to r0 with 0xFF followed by a read of r0 -> 0.
- Branch taken with forwarding:
  - Stimulus: r1=5, r2=7, InstrD=0x10220003 (beq r1,r2,3), PCPlus4D=0x10, ForwardBD=1, ALUOutM=5.
  - Required: PCSrcD=1, PCBranchD=0x13.
  - With ForwardBD=0 instead: PCSrcD=0.
- Flush: lw decoded with FlushE=1 -> RegWriteE=MemtoRegE=MemWriteE=0 on the next edge; the following unflushed sw 0xAC0A0008 -> MemWriteE=1, SignImmE=8.
- Sign extension and unknown opcode:
  - addi with imm 0xFFFC -> SignImmE=0xFFFFFFFC.
  - Opcode 0x3F -> all controls 0.
